// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   SEG_BLANK / AN_OFF : all-dark pin levels (active-low outputs)
//   disp_set_t         : one complete display configuration (shadow or active)
//   hex2seg            : hex nibble -> active-low gfedcba segment code
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_en;
    logic        blank_lz;
  } disp_set_t;

  localparam disp_set_t DISP_RESET = '{
    value:    32'h0,
    dp_mask:  8'h00,
    digit_en: 8'hFF,
    blank_lz: 1'b0
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to seven-segment decoder (purely combinational).
//   nib_i : hex digit to display
//   seg_o : active-low segments, bit0=a .. bit6=g
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// The CPU presents a word and pulses load_i; the value lands in a shadow set
// and is promoted to the active set only on a frame boundary, so a frame is
// never drawn from a half-updated value.
//   clk, rst     : clock, asynchronous active-high reset
//   value_i      : 8 hex nibbles, nibble k on digit k (digit 0 rightmost)
//   dp_mask_i    : decimal point enables per digit
//   digit_en_i   : per-digit enables (0 = dark)
//   blank_lz_i   : leading-zero blanking enable
//   load_i       : strobe capturing the four inputs above into the shadow set
//   seg, an, dp  : active-low display pins (registered)
//   frame_o      : one-cycle pulse after the active set is refreshed
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int DEAD_CYC    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic [7:0]  dp_mask_i,
  input  logic [7:0]  digit_en_i,
  input  logic        blank_lz_i,
  input  logic        load_i,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp,
  output logic        frame_o
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CYC_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CYC_DEAD = CW'(DEAD_CYC);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    idx_q, idx_d;
  disp_set_t     shadow_q, shadow_d;
  disp_set_t     active_q, active_d;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          frame_q, frame_d;

  disp_set_t     load_set;
  logic          slot_end, frame_end;
  logic          upper_zero, lz_blank, lit;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  seg7_decoder u_dec (
    .nib_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    load_set = '{
      value:    value_i,
      dp_mask:  dp_mask_i,
      digit_en: digit_en_i,
      blank_lz: blank_lz_i
    };

    slot_end  = (cyc_q == CYC_LAST);
    frame_end = slot_end && (idx_q == 3'd7);
    cyc_d     = slot_end ? '0 : cyc_q + CW'(1);
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;

    // Promoting shadow_d (not shadow_q) lets a load on the boundary cycle
    // reach the active set directly instead of waiting a whole frame.
    shadow_d  = load_i ? load_set : shadow_q;
    active_d  = frame_end ? shadow_d : active_q;
    frame_d   = frame_end;

    // A digit is a leading zero when it and every more-significant nibble
    // are zero; digit 0 is exempt so a zero value still shows "0".
    upper_zero = ((active_q.value >> {idx_q, 2'b00}) == 32'h0);
    lz_blank   = active_q.blank_lz && (idx_q != 3'd0) && upper_zero;
    lit        = (cyc_q >= CYC_DEAD) && active_q.digit_en[idx_q] && !lz_blank;
    nibble     = active_q.value[{idx_q, 2'b00} +: 4];

    an_d  = lit ? ~(8'b1 << idx_q) : AN_OFF;
    seg_d = lit ? dec_seg : SEG_BLANK;
    dp_d  = lit ? ~active_q.dp_mask[idx_q] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q    <= '0;
      idx_q    <= '0;
      shadow_q <= DISP_RESET;
      active_q <= DISP_RESET;
      seg_q    <= SEG_BLANK;
      an_q     <= AN_OFF;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cyc_q    <= cyc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=4, DEAD_CYC=1.
module tb_seg7_scan_driver;

  localparam int RD    = 4;
  localparam int DC    = 1;
  localparam int FRAME = 8 * RD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  dm;
    logic [7:0]  en;
    logic        lz;
  } set_t;

  localparam set_t SET_DEFAULT = '{v: 32'h0, dm: 8'h00, en: 8'hFF, lz: 1'b0};

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [7:0]  digit_en;
    logic        lz;
    logic [7:0]  lit;    // digits expected lit
    logic [55:0] segs;   // digit k expected seg at [7k +: 7]
    logic [7:0]  dp_n;   // expected dp pin per digit
  } vec_t;

  logic        clk, rst;
  logic [31:0] value_i;
  logic [7:0]  dp_mask_i, digit_en_i;
  logic        blank_lz_i, load_i;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp, frame_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   p        = 0;   // clock edges since reset release
  set_t m_act, m_sh;

  seg7_scan_driver #(.REFRESH_DIV(RD), .DEAD_CYC(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .dp_mask_i  (dp_mask_i),
    .digit_en_i (digit_en_i),
    .blank_lz_i (blank_lz_i),
    .load_i     (load_i),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_o    (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (pos %0d, t=%0t)", nm, act, exp, p, $time);
    end
  endtask

  // Expected {an, seg, dp} for a display set when the pins show position pos.
  function automatic logic [15:0] model_pins(input set_t s, input int pos);
    int          cyc = pos % RD;
    int          idx = (pos / RD) % 8;
    logic [31:0] upper = s.v >> (4 * idx);
    logic [7:0]  a = 8'hFF;
    if (cyc < DC || !s.en[idx] || (s.lz && idx > 0 && upper == 0))
      return {8'hFF, 7'h7F, 1'b1};
    a[idx] = 1'b0;
    return {a, SEG_TAB[upper[3:0]], ~s.dm[idx]};
  endfunction

  task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] dm,
                      input logic [7:0] en, input logic lz);
    logic [15:0] e;
    load_i = ld; value_i = v; dp_mask_i = dm; digit_en_i = en; blank_lz_i = lz;
    @(posedge clk);
    #1;
    e = model_pins(m_act, p);
    check("pins", {16'h0, an, seg, dp}, {16'h0, e});
    check("frame_o", {31'h0, frame_o}, {31'h0, (p % FRAME) == FRAME - 1});
    if (ld) m_sh = '{v: v, dm: dm, en: en, lz: lz};
    if ((p % FRAME) == FRAME - 1) m_act = m_sh;
    p++;
    load_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, value_i, dp_mask_i, digit_en_i, blank_lz_i);
  endtask

  task automatic wait_frame(input string nm);
    logic got = 1'b0;
    for (int k = 0; k < FRAME + 8 && !got; k++) begin
      idle(1);
      got = frame_o;
    end
    check(nm, {31'h0, got}, 32'h1);
  endtask

  task automatic model_reset();
    p     = 0;
    m_act = SET_DEFAULT;
    m_sh  = SET_DEFAULT;
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{value: 32'h0000_0000, dp_mask: 8'h00, digit_en: 8'hFF, lz: 1'b0, lit: 8'hFF,
                segs: {8{7'h40}}, dp_n: 8'hFF};
    vecs[1] = '{value: 32'h0000_7F39, dp_mask: 8'h00, digit_en: 8'hFF, lz: 1'b1, lit: 8'h0F,
                segs: {{4{7'h7F}}, 7'h78, 7'h0E, 7'h30, 7'h10}, dp_n: 8'hFF};
    vecs[2] = '{value: 32'hABCD_EF01, dp_mask: 8'h04, digit_en: 8'hF0, lz: 1'b0, lit: 8'hF0,
                segs: {7'h08, 7'h03, 7'h46, 7'h21, {4{7'h7F}}}, dp_n: 8'hFF};
    vecs[3] = '{value: 32'h0000_0000, dp_mask: 8'h00, digit_en: 8'hFF, lz: 1'b1, lit: 8'h01,
                segs: {{7{7'h7F}}, 7'h40}, dp_n: 8'hFF};
    vecs[4] = '{value: 32'h0000_1020, dp_mask: 8'h06, digit_en: 8'hFF, lz: 1'b1, lit: 8'h0F,
                segs: {{4{7'h7F}}, 7'h79, 7'h40, 7'h24, 7'h40}, dp_n: 8'hF9};

    rst = 1'b1; load_i = 1'b0; value_i = '0; dp_mask_i = '0; digit_en_i = 8'hFF; blank_lz_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", {16'h0, an, seg, dp}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    check("reset_frame", {31'h0, frame_o}, 32'h0);
    rst = 1'b0;
    model_reset();

    // Idle after reset: digit 0 first, an low from the second edge.
    idle(2);
    check("first_lit_an", {24'h0, an}, 32'h0000_00FE);
    check("first_lit_seg", {25'h0, seg}, 32'h40);
    wait_frame("idle_frame");

    // Table vectors: load, wait for promotion, then sweep one frame.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].value, vecs[i].dp_mask, vecs[i].digit_en, vecs[i].lz);
      wait_frame("vec_frame");
      for (int k = 0; k < 8; k++) begin
        logic [7:0] ea;
        idle(k == 0 ? 3 : 4);
        ea = 8'hFF;
        if (vecs[i].lit[k]) ea[k] = 1'b0;
        check($sformatf("vec%0d_d%0d_an", i, k), {24'h0, an}, {24'h0, ea});
        check($sformatf("vec%0d_d%0d_seg", i, k), {25'h0, seg}, {25'h0, vecs[i].segs[7*k +: 7]});
        check($sformatf("vec%0d_d%0d_dp", i, k), {31'h0, dp}, {31'h0, vecs[i].dp_n[k]});
      end
    end

    // Load on the exact frame-boundary cycle goes straight to the display.
    for (int k = 0; k < FRAME + 8 && (p % FRAME) != FRAME - 1; k++) idle(1);
    check("boundary_align", p % FRAME, FRAME - 1);
    step(1'b1, 32'h0000_0008, 8'h00, 8'hFF, 1'b0);
    check("boundary_frame", {31'h0, frame_o}, 32'h1);
    idle(3);
    check("boundary_an", {24'h0, an}, 32'h0000_00FE);
    check("boundary_seg", {25'h0, seg}, 32'h00);

    // Back-to-back loads: the later one wins.
    step(1'b1, 32'h0000_0001, 8'h00, 8'hFF, 1'b0);
    step(1'b1, 32'h0000_0002, 8'h00, 8'hFF, 1'b0);
    wait_frame("b2b_frame");
    idle(3);
    check("b2b_seg", {25'h0, seg}, 32'h24);

    // Reset mid-slot while digit 3 is lit blanks the pins without a clock edge.
    for (int k = 0; k < FRAME + 8 && an != 8'hF7; k++) idle(1);
    check("reach_digit3", {24'h0, an}, 32'h0000_00F7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pins", {16'h0, an, seg, dp}, {16'h0, 8'hFF, 7'h7F, 1'b1});
    check("async_rst_frame", {31'h0, frame_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(2);
    check("restart_an", {24'h0, an}, 32'h0000_00FE);
    check("restart_seg", {25'h0, seg}, 32'h40);
    wait_frame("restart_frame");

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] rv = $urandom >> $urandom_range(0, 31);
      step(($urandom_range(0, 5) == 0), rv, 8'($urandom), 8'($urandom | $urandom),
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
